// File: rtl/dffram_pkg.sv
// dffram_pkg -- shared defaults and the loader state encoding.
//   ADDR_W_DEF : default RAM word-address width
//   DATA_W_DEF : default RAM word width (byte lanes = DATA_W/8)
//   ld_state_t : loader FSM states
package dffram_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    VRD,
    VWAIT,
    DONE
  } ld_state_t;

endpackage

// File: rtl/dffram_byte_packer.sv
// dffram_byte_packer -- gathers a byte stream into little-endian RAM words.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   i_en                  : collection window; drives byte_ready_o directly
//   byte_valid_i, byte_i  : byte stream input
//   byte_ready_o          : byte stream ready
//   o_word, o_word_valid  : completed word, valid for the cycle the last byte
//                           transfers (combinational from the final byte)
module dffram_byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_en,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_valid
);

  localparam int LANES = DATA_W / 8;
  localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;

  logic [CW-1:0]     r_lane;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] w_word;
  logic              w_xfer;
  logic              w_last;

  assign byte_ready_o = i_en;
  assign w_xfer       = byte_valid_i & i_en;
  assign w_last       = w_xfer && (r_lane == CW'(LANES - 1));

  // Merge the incoming byte into its lane so the final byte is visible the
  // same cycle it transfers; the loader registers the result.
  always_comb begin
    w_word = r_word;
    w_word[{r_lane, 3'b000} +: 8] = byte_i;
  end

  assign o_word       = w_word;
  assign o_word_valid = w_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (w_xfer) begin
      r_word <= w_word;
      r_lane <= w_last ? '0 : r_lane + 1'b1;
    end
  end

endmodule

// File: rtl/dffram_loader.sv
// dffram_loader -- streams bytes into a RAM word by word, keeps an additive
// checksum, and optionally re-reads the range to confirm it.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   start_i                      : begin a load (accepted in IDLE only)
//   base_addr_i, word_count_i    : first word address, word count (0..2^ADDR_W)
//   verify_i                     : run a read-back checksum pass after writing
//   byte_valid_i/byte_i/byte_ready_o : byte stream handshake
//   ram_en_o/ram_we_o/ram_a_o/ram_di_o : RAM initiator port
//   ram_do_i                     : RAM read data, one cycle after a read
//   busy_o, done_o (pulse), err_o, checksum_o : status
// All outputs are registered; done_o is raised as DONE hands back to IDLE.
module dffram_loader
  import dffram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W:0]     word_count_i,
  input  logic                verify_i,
  input  logic                byte_valid_i,
  input  logic [7:0]          byte_i,
  output logic                byte_ready_o,
  output logic                ram_en_o,
  output logic [DATA_W/8-1:0] ram_we_o,
  output logic [ADDR_W-1:0]   ram_a_o,
  output logic [DATA_W-1:0]   ram_di_o,
  input  logic [DATA_W-1:0]   ram_do_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [DATA_W-1:0]   checksum_o
);

  localparam int LANES = DATA_W / 8;

  ld_state_t         r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_rem;
  logic              r_verify;
  logic              r_ready;
  logic              r_ram_en;
  logic [LANES-1:0]  r_ram_we;
  logic [ADDR_W-1:0] r_ram_a;
  logic [DATA_W-1:0] r_ram_di;
  logic [DATA_W-1:0] r_chk;
  logic [DATA_W-1:0] r_shadow;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [DATA_W-1:0] w_word;
  logic              w_word_valid;
  logic [DATA_W-1:0] w_vsum;

  dffram_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_en         (r_ready),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  assign w_vsum = r_shadow + ram_do_i;

  // r_addr always holds the address of the next word to touch; RAM port
  // registers are loaded on the transition into WRITE/VRD so they line up
  // with those states.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_addr   <= '0;
      r_count  <= '0;
      r_rem    <= '0;
      r_verify <= 1'b0;
      r_ready  <= 1'b0;
      r_ram_en <= 1'b0;
      r_ram_we <= '0;
      r_ram_a  <= '0;
      r_ram_di <= '0;
      r_chk    <= '0;
      r_shadow <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_base   <= base_addr_i;
            r_addr   <= base_addr_i;
            r_count  <= word_count_i;
            r_rem    <= word_count_i;
            r_verify <= verify_i;
            r_chk    <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            if (word_count_i == '0) begin
              r_state <= DONE;
            end else begin
              r_state <= COLLECT;
              r_ready <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (w_word_valid) begin
            r_state  <= WRITE;
            r_ready  <= 1'b0;
            r_ram_en <= 1'b1;
            r_ram_we <= '1;
            r_ram_a  <= r_addr;
            r_ram_di <= w_word;
            r_chk    <= r_chk + w_word;
            r_addr   <= r_addr + 1'b1;
            r_rem    <= r_rem - 1'b1;
          end
        end
        WRITE: begin
          r_ram_en <= 1'b0;
          r_ram_we <= '0;
          if (r_rem != '0) begin
            r_state <= COLLECT;
            r_ready <= 1'b1;
          end else if (r_verify) begin
            r_state  <= VRD;
            r_addr   <= r_base;
            r_rem    <= r_count;
            r_shadow <= '0;
            r_ram_en <= 1'b1;
            r_ram_a  <= r_base;
          end else begin
            r_state <= DONE;
          end
        end
        VRD: begin
          r_ram_en <= 1'b0;
          r_state  <= VWAIT;
        end
        VWAIT: begin
          r_shadow <= w_vsum;
          r_addr   <= r_addr + 1'b1;
          r_rem    <= r_rem - 1'b1;
          if (r_rem != (ADDR_W+1)'(1)) begin
            r_state  <= VRD;
            r_ram_en <= 1'b1;
            r_ram_a  <= r_addr + 1'b1;
          end else begin
            r_state <= DONE;
            r_err   <= (w_vsum != r_chk);
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_en_o   = r_ram_en;
  assign ram_we_o   = r_ram_we;
  assign ram_a_o    = r_ram_a;
  assign ram_di_o   = r_ram_di;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign checksum_o = r_chk;

endmodule

// File: tb/tb_dffram_loader.sv
module tb_dffram_loader;

  typedef struct packed {
    logic [3:0]  we;
    logic [11:0] a;
    logic [31:0] d;
  } ram_op_t;

  logic        clk = 1'b0;
  logic        rst_i, start_i, verify_i, byte_valid_i;
  logic [11:0] base_addr_i;
  logic [12:0] word_count_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o, ram_en_o, busy_o, done_o, err_o;
  logic [3:0]  ram_we_o;
  logic [11:0] ram_a_o;
  logic [31:0] ram_di_o, ram_do_i, checksum_o;

  always #5 clk = ~clk;

  dffram_loader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .word_count_i(word_count_i), .verify_i(verify_i), .byte_valid_i(byte_valid_i),
    .byte_i(byte_i), .byte_ready_o(byte_ready_o), .ram_en_o(ram_en_o),
    .ram_we_o(ram_we_o), .ram_a_o(ram_a_o), .ram_di_o(ram_di_o), .ram_do_i(ram_do_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .checksum_o(checksum_o)
  );

  // RAM model; optionally corrupts word 0x011 as it is written.
  logic [31:0] mem [0:4095];
  logic        corrupt = 1'b0;
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o != 4'h0)
        mem[ram_a_o] <= (corrupt && ram_a_o == 12'h011) ? 32'h88776656 : ram_di_o;
      ram_do_i <= mem[ram_a_o];
    end
  end

  int      n_chk = 0;
  int      n_err = 0;
  int      n_done = 0;
  ram_op_t sb[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge, RAM ops popped from the scoreboard.
  task automatic cyc();
    ram_op_t e;
    ram_op_t got;
    @(posedge clk);
    @(negedge clk);
    if (done_o) n_done++;
    if (ram_en_o) begin
      if (sb.size() == 0) begin
        chk("ram_unexpected", ram_en_o, 1'b0);
      end else begin
        e   = sb.pop_front();
        got = '{we: ram_we_o, a: ram_a_o, d: (ram_we_o != 4'h0) ? ram_di_o : 32'h0};
        chk("ram_op", got, e);
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    logic x;
    bit   ok;
    if (gap) repeat ($urandom_range(0, 2)) cyc();
    byte_i = b;
    byte_valid_i = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      x = byte_ready_o;
      cyc();
      if (x) begin ok = 1'b1; break; end
    end
    chk("byte_xfer", ok, 1'b1);
    byte_valid_i = 1'b0;
  endtask

  task automatic load(input logic [11:0] base, input int cnt, input bit ver,
                      input logic [7:0] bq[$], input bit gap, input bit poke,
                      input bit exp_err, input string tag);
    logic [31:0] sum;
    logic [31:0] d;
    sum = 32'h0;
    for (int w = 0; w < cnt; w++) begin
      d = {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
      sum += d;
      sb.push_back('{we: 4'hF, a: 12'(base + w), d: d});
    end
    if (ver)
      for (int w = 0; w < cnt; w++) sb.push_back('{we: 4'h0, a: 12'(base + w), d: 32'h0});
    n_done = 0;
    base_addr_i = base; word_count_i = 13'(cnt); verify_i = ver; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    for (int i = 0; i < bq.size(); i++) begin
      if (poke && i == 2) begin
        start_i = 1'b1; base_addr_i = 12'h100; word_count_i = 13'h0;
        cyc();
        start_i = 1'b0;
      end
      send(bq[i], gap);
    end
    for (int k = 0; k < 400 && n_done == 0; k++) cyc();
    chk({tag, "_done_seen"}, n_done, 1);
    cyc(); cyc();
    chk({tag, "_one_done"}, n_done, 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_checksum"}, checksum_o, sum);
    chk({tag, "_err"}, err_o, exp_err);
    chk({tag, "_idle"}, busy_o, 1'b0);
  endtask

  logic [7:0] b033[$];
  logic [7:0] b034[$];
  logic [7:0] b037[$];

  initial begin
    rst_i = 1'b1; start_i = 1'b0; verify_i = 1'b0; byte_valid_i = 1'b0;
    base_addr_i = '0; word_count_i = '0; byte_i = '0;
    b033 = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    b034 = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    b037 = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    cyc(); cyc();
    chk("reset_outputs", {byte_ready_o, ram_en_o, ram_we_o, ram_a_o, ram_di_o,
                          busy_o, done_o, err_o, checksum_o}, '0);
    rst_i = 1'b0;
    cyc();

    // Two words with read-back verify.
    load(12'h010, 2, 1'b1, b033, 1'b0, 1'b0, 1'b0, "t_basic");
    chk("t_basic_sum_const", checksum_o, 32'hCCAA8866);

    // Address wrap at the top of the RAM.
    load(12'hFFF, 2, 1'b0, b034, 1'b0, 1'b0, 1'b0, "t_wrap");

    // Corrupted RAM word must be flagged, and the flag must hold.
    corrupt = 1'b1;
    load(12'h010, 2, 1'b1, b033, 1'b0, 1'b0, 1'b1, "t_corrupt");
    corrupt = 1'b0;
    repeat (5) cyc();
    chk("t_corrupt_err_hold", err_o, 1'b1);
    chk("t_corrupt_sum_hold", checksum_o, 32'hCCAA8866);

    // Zero-length load: done two cycles after start sampled, no RAM access.
    n_done = 0;
    base_addr_i = 12'h055; word_count_i = 13'h0; verify_i = 1'b1; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("t_zero_done_c1", done_o, 1'b0);
    chk("t_zero_busy_c1", busy_o, 1'b1);
    chk("t_zero_err_clr", err_o, 1'b0);
    cyc();
    chk("t_zero_done_c2", done_o, 1'b1);
    chk("t_zero_sum", checksum_o, 32'h0);
    cyc();
    chk("t_zero_done_pulse", done_o, 1'b0);
    chk("t_zero_one_done", n_done, 1);

    // Reset in the middle of collecting a word.
    base_addr_i = 12'h020; word_count_i = 13'h1; verify_i = 1'b0; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    rst_i = 1'b1;
    cyc();
    chk("t_midrst_outputs", {byte_ready_o, ram_en_o, ram_we_o, ram_a_o, ram_di_o,
                             busy_o, done_o, err_o, checksum_o}, '0);
    rst_i = 1'b0;
    cyc();
    load(12'h020, 1, 1'b0, b037, 1'b0, 1'b0, 1'b0, "t_after_rst");

    // Gappy byte stream plus a start pulse while busy.
    load(12'h010, 2, 1'b1, b033, 1'b1, 1'b1, 1'b0, "t_gaps");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dffram_loader.md
DFFRAM_LOADER -- requirements
Module: dffram_loader

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the RAM word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the RAM word width (byte-lane count DATA_W/8).
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 start_i  in  1  begin a load; sampled in IDLE only.
REQ-006 base_addr_i  in  ADDR_W  first RAM word address; latched on start.
REQ-007 word_count_i  in  ADDR_W+1  number of words to load (0..4096); latched on start.
REQ-008 verify_i  in  1  read-back checksum pass after writes; latched on start.
REQ-009 byte_valid_i / byte_i[7:0] / byte_ready_o  in/in/out  byte-stream valid/ready handshake.
REQ-010 ram_en_o, ram_we_o[3:0], ram_a_o[ADDR_W-1:0], ram_di_o[31:0]  out  RAM initiator port (enable, byte write mask, address, write data).
REQ-011 ram_do_i[31:0]  in  RAM read data, valid one cycle after a read enable.
REQ-012 busy_o  out  1; done_o  out  1 (pulse); err_o  out  1; checksum_o  out  32.

Function
REQ-013 FSM states SHALL be IDLE, COLLECT, WRITE, VRD, VWAIT, DONE.
REQ-014 IDLE + start_i: latch inputs, clear checksum/err, go COLLECT (count>0) or DONE (count=0).
REQ-015 start_i outside IDLE SHALL be ignored.
REQ-016 byte_ready_o SHALL be 1 only in COLLECT; a byte transfers when byte_valid_i & byte_ready_o.
REQ-017 Bytes pack little-endian: first byte -> bits 7:0, fourth -> 31:24; after fourth transfer go WRITE.
REQ-018 WRITE lasts exactly 1 cycle: ram_en_o=1, ram_we_o=4'hF, ram_a_o=current addr, ram_di_o=packed word.
REQ-019 In WRITE: checksum += word (mod 2^32), addr += 1 (mod 2^ADDR_W, wraps 0xFFF->0x000), remaining -= 1.
REQ-020 After WRITE: remaining>0 -> COLLECT; else verify latched -> VRD (addr reset to base, remaining reloaded, shadow sum cleared); else DONE.
REQ-021 VRD: ram_en_o=1, ram_we_o=0, ram_a_o=addr; next state VWAIT.
REQ-022 VWAIT: shadow sum += ram_do_i; addr += 1; remaining -= 1; remaining>0 -> VRD else DONE; 2 cycles per verified word.
REQ-023 Entering DONE from verify: err_o SHALL set if shadow sum != checksum.
REQ-024 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-025 ram_en_o=0 and ram_we_o=0 in every state except WRITE/VRD as specified.
REQ-026 busy_o=1 in all states except IDLE.
REQ-027 checksum_o and err_o SHALL hold their values until next accepted start.
REQ-028 Latency: count=0 start -> done_o 2 cycles after start sampled; no RAM access.

Reset
REQ-029 rst_i SHALL force IDLE and zero every output, counter, partial word and checksum on the next edge, including mid-operation; partial word discarded, no further RAM access.
REQ-030 Reset values: byte_ready_o=0, ram_en_o=0, ram_we_o=0, ram_a_o=0, ram_di_o=0, busy_o=0, done_o=0, err_o=0, checksum_o=0.

Structure
REQ-031 Package dffram_pkg SHALL hold ADDR_W/DATA_W defaults and the loader state enum.
REQ-032 One sub-module, dffram_byte_packer (byte handshake -> 32-bit word + word_valid), SHALL be instantiated; FSM, counters and checksum stay in dffram_loader.

Verification
REQ-033 base=0x010, count=2, verify=1, bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211@0x010, 0x88776655@0x011, we=F; reads 0x010,0x011; checksum_o=0xCCAA8866, err_o=0, one done_o pulse.
REQ-034 base=0xFFF, count=2, verify=0 -> write addresses 0xFFF then 0x000.
REQ-035 count=0 -> no ram_en_o, done_o 2 cycles after start, checksum_o=0.
REQ-036 RAM model corrupts word 0x011 to 0x88776656 before verify -> err_o=1 at done, stays 1 until next start.
REQ-037 rst_i after 2 bytes in COLLECT -> all outputs 0 next cycle; new start with 4 bytes AA BB CC DD writes 0xDDCCBBAA.
REQ-038 byte_valid_i with random gaps plus start_i pulsed while busy -> identical writes to REQ-033, second start ignored.
